decode_cycle: RTL and testbench

//   Instruction-decode stage of the 16-bit pipelined processor. Splits the

---
 rtl/decode_cycle_pkg.sv | 18 +
 rtl/decode_cycle_regfile.sv | 31 +++
 rtl/decode_cycle.sv | 57 +++++
 tb/tb_decode_cycle.sv | 117 +++++++++++
 4 files changed

// File: rtl/decode_cycle_pkg.sv
// decode_cycle_pkg: shared widths, field positions and opcode classes for the decode stage
package decode_cycle_pkg;
  localparam int XLEN = 16;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS = 16;
  localparam int OP_LSB = 0;
  localparam int RD_LSB = 4;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 12;
  localparam logic [3:0] OP_I_LO = 4'h4;
  localparam logic [3:0] OP_U_LO = 4'hC;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [REG_IDX_W-1:0] ridx_t;
  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_U} op_class_t;
  function automatic op_class_t op_class(input logic [3:0] op);
    return op < OP_I_LO ? CLS_R : op < OP_U_LO ? CLS_I : CLS_U;
  endfunction
endpackage

// File: rtl/decode_cycle_regfile.sv
// decode_cycle_regfile: 16x16 register file, reset-to-index, hard-zero reg0, write-to-read bypass
module decode_cycle_regfile
  import decode_cycle_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  ridx_t waddr,
  input  word_t wdata,
  input  ridx_t raddr1,
  input  ridx_t raddr2,
  output word_t rdata1,
  output word_t rdata2
);
  word_t regs [NUM_REGS];
  logic wr_en;
  assign wr_en = we && waddr != '0;
  // reset loads each register with its own index; writes to reg0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= word_t'(i);
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end
  // reg0 reads zero; a same-cycle write to the read index is forwarded
  always_comb begin
    rdata1 = raddr1 == '0 ? '0 : (wr_en && raddr1 == waddr) ? wdata : regs[raddr1];
    rdata2 = raddr2 == '0 ? '0 : (wr_en && raddr2 == waddr) ? wdata : regs[raddr2];
  end
endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: instruction decode with register read, immediate generation and ID/EX register
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [15:0] pc,
  input  logic [15:0] writedata,
  input  logic        regwrite,
  output logic [15:0] pcout,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [3:0]  rdout,
  output logic [15:0] imm
);
  ridx_t rd, rs1, rs2;
  word_t rdata1, rdata2, imm_d;
  op_class_t cls;
  assign rd  = ir[RD_LSB +: REG_IDX_W];
  assign rs1 = ir[RS1_LSB +: REG_IDX_W];
  assign rs2 = ir[RS2_LSB +: REG_IDX_W];
  assign cls = op_class(ir[OP_LSB +: 4]);
  decode_cycle_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (regwrite),
    .waddr  (rd),
    .wdata  (writedata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );
  // R-type has no immediate; I-class uses a 4-bit field, U-class an 8-bit field
  always_comb begin
    imm_d = cls == CLS_R ? '0
          : cls == CLS_I ? {{12{ir[15]}}, ir[15:12]}
          : {{8{ir[15]}}, ir[15:8]};
  end
  // ID/EX pipeline register, one instruction per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pcout <= '0;
      a     <= '0;
      b     <= '0;
      rdout <= '0;
      imm   <= '0;
    end else begin
      pcout <= pc;
      a     <= rdata1;
      b     <= rdata2;
      rdout <= rd;
      imm   <= imm_d;
    end
  end
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed table plus randomized checking against a behavioural model
module tb_decode_cycle;
  logic clk = 0, rst = 0, regwrite = 0;
  logic [15:0] ir = 0, pc = 0, writedata = 0;
  logic [15:0] pcout, a, b, imm;
  logic [3:0] rdout;
  int n_vec = 0, n_fail = 0;
  typedef struct {
    logic rst; logic [15:0] ir, pc, wd; logic rw;
    logic [15:0] a, b, imm, pcout; logic [3:0] rd;
  } vec_t;
  vec_t tbl[$];
  int model [16];

  decode_cycle dut (
    .clk(clk), .rst(rst), .ir(ir), .pc(pc), .writedata(writedata), .regwrite(regwrite),
    .pcout(pcout), .a(a), .b(b), .rdout(rdout), .imm(imm)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [15:0] i, logic [15:0] p, logic [15:0] w, logic rw,
                              logic [15:0] ea, logic [15:0] eb, logic [3:0] erd, logic [15:0] ei, logic [15:0] ep);
    vec_t v;
    v.rst = r; v.ir = i; v.pc = p; v.wd = w; v.rw = rw;
    v.a = ea; v.b = eb; v.rd = erd; v.imm = ei; v.pcout = ep;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(logic r, logic [15:0] i, logic [15:0] p, logic [15:0] w, logic rw);
    rst = r; ir = i; pc = p; writedata = w; regwrite = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, logic [15:0] ea, logic [15:0] eb, logic [3:0] erd, logic [15:0] ei, logic [15:0] ep);
    chk("a", idx, a, ea);
    chk("b", idx, b, eb);
    chk("rdout", idx, {12'h0, rdout}, {12'h0, erd});
    chk("imm", idx, imm, ei);
    chk("pcout", idx, pcout, ep);
  endtask

  function automatic logic [15:0] ref_imm(logic [15:0] i);
    int op = i % 16;
    int v;
    if (op < 4) return 16'h0;
    if (op < 12) begin v = i / 4096; if (v >= 8) v -= 16; end
    else begin v = i / 256; if (v >= 128) v -= 256; end
    return 16'(v);
  endfunction

  function automatic logic [15:0] ref_read(int rs, int rd, logic rw, logic [15:0] wd);
    if (rs == 0) return 16'h0;
    if (rw && rs == rd) return wd;
    return 16'(model[rs]);
  endfunction

  initial begin
    // sequential directed vectors; expectations follow from the state left by earlier rows
    tbl.push_back(mk(1, 16'h2160, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 16'h2160, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0002, 4'h6, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 16'h6600, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0002));
    tbl.push_back(mk(0, 16'h0000, 16'h0004, 16'h0000, 0, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0004));
    tbl.push_back(mk(0, 16'h0330, 16'h0006, 16'hBEEF, 1, 16'hBEEF, 16'h0000, 4'h3, 16'h0000, 16'h0006));
    tbl.push_back(mk(0, 16'h4300, 16'h0008, 16'h0000, 0, 16'hBEEF, 16'h0004, 4'h0, 16'h0000, 16'h0008));
    tbl.push_back(mk(0, 16'hF104, 16'h0042, 16'h0000, 0, 16'h0001, 16'h000F, 4'h0, 16'hFFFF, 16'h0042));
    tbl.push_back(mk(0, 16'h7A0C, 16'h0044, 16'h0000, 0, 16'h000A, 16'h0007, 4'h0, 16'h007A, 16'h0044));
    tbl.push_back(mk(0, 16'h8A0C, 16'h0046, 16'h0000, 0, 16'h000A, 16'h0008, 4'h0, 16'hFF8A, 16'h0046));
    tbl.push_back(mk(0, 16'h0050, 16'h0048, 16'h1234, 1, 16'h0000, 16'h0000, 4'h5, 16'h0000, 16'h0048));
    tbl.push_back(mk(0, 16'h5500, 16'h004A, 16'h0000, 0, 16'h1234, 16'h1234, 4'h0, 16'h0000, 16'h004A));
    tbl.push_back(mk(1, 16'h5550, 16'h004C, 16'h9999, 1, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 16'h5500, 16'h004E, 16'h0000, 0, 16'h0005, 16'h0005, 4'h0, 16'h0000, 16'h004E));
    tbl.push_back(mk(0, 16'h0000, 16'h0050, 16'hFFFF, 1, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0050));
    tbl.push_back(mk(0, 16'h0000, 16'h0052, 16'h0000, 0, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0052));
    tbl.push_back(mk(0, 16'h9B1B, 16'h1234, 16'h0000, 0, 16'h000B, 16'h0009, 4'h1, 16'hFFF9, 16'h1234));
    tbl.push_back(mk(0, 16'h7213, 16'h1236, 16'h0000, 0, 16'h0002, 16'h0007, 4'h1, 16'h0000, 16'h1236));
    tbl.push_back(mk(0, 16'h7070, 16'h1238, 16'hAAAA, 1, 16'h0000, 16'hAAAA, 4'h7, 16'h0000, 16'h1238));
    tbl.push_back(mk(0, 16'h0700, 16'h123A, 16'h0000, 0, 16'hAAAA, 16'h0000, 4'h0, 16'h0000, 16'h123A));
    @(negedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rst, tbl[k].ir, tbl[k].pc, tbl[k].wd, tbl[k].rw);
      check_all(k, tbl[k].a, tbl[k].b, tbl[k].rd, tbl[k].imm, tbl[k].pcout);
    end
    // randomized phase starts from a reset so the model and the DUT agree
    for (int k = 0; k < 400; k++) begin
      logic r, rw;
      logic [15:0] i, p, w, ea, eb, ei, ep;
      logic [3:0] erd;
      int rd, rs1, rs2;
      r = (k == 0) || ($urandom_range(31) == 0);
      i = 16'($urandom); p = 16'($urandom); w = 16'($urandom); rw = 1'($urandom);
      rd = (i / 16) % 16; rs1 = (i / 256) % 16; rs2 = i / 4096;
      if (r) begin
        ea = 0; eb = 0; erd = 0; ei = 0; ep = 0;
      end else begin
        ea = ref_read(rs1, rd, rw, w);
        eb = ref_read(rs2, rd, rw, w);
        erd = 4'(rd); ei = ref_imm(i); ep = p;
      end
      step(r, i, p, w, rw);
      check_all(1000 + k, ea, eb, erd, ei, ep);
      if (r) for (int j = 0; j < 16; j++) model[j] = j;
      else if (rw && rd != 0) model[rd] = int'(w);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
